cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 Parameter: LEN_W, default 4, width of per-requester burst length; max burst 2^LEN_W-1 counts.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  3  req[i] high: requester i asks for one counting burst; held until its done pulse.
REQ-005 req_len  input  3*LEN_W  bits [LEN_W*i+LEN_W-1 : LEN_W*i] = burst length of requester i; sampled only in the grant cycle.
REQ-006 abort  input  1  terminates the active burst; ignored outside RUN.
REQ-007 gnt  output  3  one-hot owner of the shared mod-12 counter; zero when idle.
REQ-008 valid_count  output  1  count enable to the shared counter; high only in RUN.
REQ-009 cnt  output  4  shadow copy of the shared counter value, range 0..11.
REQ-010 wrap  output  1  one-cycle pulse on each 11->0 step of cnt.
REQ-011 done  output  3  one-cycle pulse to the owner when its burst ends.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; gnt, valid_count, done and busy SHALL be decoded from registered state and owner, with no combinational path from inputs.
REQ-014 In IDLE with req!=0, the block SHALL pick a winner, latch its req_len into rem, and load owner on the same edge.
REQ-015 On that edge, the FSM SHALL go IDLE->RUN if the latched length is nonzero, else IDLE->DONE.
REQ-016 Latency: with req seen in IDLE at cycle t, gnt SHALL be high t+1..t+L+1, valid_count high t+1..t+L, and done[owner] high at t+L+1, where L is the burst length.
REQ-017 Each RUN cycle SHALL decrement rem and advance cnt by one mod 12 (11->0 sets wrap for one cycle).
REQ-018 RUN SHALL go to DONE on the edge where rem==1 or abort==1.
REQ-019 Abort SHALL discard the remaining counts; the count of the abort cycle itself SHALL be taken.
REQ-020 DONE SHALL last exactly one cycle: done[owner]=1 and valid_count=0, then the FSM SHALL return to IDLE with gnt=0.
REQ-021 Dropping req during RUN SHALL NOT end the burst; ownership SHALL be held until DONE.
REQ-022 A req still high in IDLE after its done pulse SHALL be treated as a new request.
REQ-023 cnt SHALL change only when valid_count=1 and SHALL persist across bursts and owners.
REQ-024 At most one gnt bit and at most one done bit SHALL be high in any cycle.
REQ-025 req or req_len changes during RUN or DONE SHALL have no effect on the current burst.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE and set gnt=0, valid_count=0, cnt=0, wrap=0, done=0, busy=0, rem=0.
REQ-027 rst_n low SHALL also set the round-robin pointer to 2, so requester 0 has first priority.
REQ-028 Reset during RUN SHALL abandon the burst with no done pulse; the first request after release SHALL be granted normally.

Configuration
REQ-029 With CNT_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at last_owner+1 mod 3, and last_owner updates at each grant.
REQ-030 Without CNT_SCHED_RR_EN, arbitration SHALL be fixed priority req[0] > req[1] > req[2], and no pointer register SHALL exist.

Verification
REQ-031 Single burst: req=001, len0=5 from reset -> gnt=001 for 6 cycles, valid_count high 5 cycles, cnt 0->5, done=001 once.
REQ-032 Wrap: cnt=9, len1=4 -> cnt sequence 10,11,0,1; wrap pulses once on the 11->0 step.
REQ-033 Abort: len2=8, abort in the 3rd RUN cycle -> 3 counts taken, done=100 next cycle, cnt advanced by 3.
REQ-034 Contention: req=111 held with all lengths 1 -> RR build grants 0,1,2,0; non-RR build grants 0,0,0.
REQ-035 Zero length: req=010, len1=0 -> gnt=010 for 1 cycle, done=010, valid_count never high, cnt unchanged.
REQ-036 Reset mid-RUN: assert rst_n low in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; after release req=001 is granted normally.

Source files
------------

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - three-requester burst scheduler owning a shared mod-12 counter
// Define CNT_SCHED_RR_EN for round-robin arbitration; fixed priority 0>1>2 otherwise.
`timescale 1ns/1ps
module cnt_sched #(
  parameter int LEN_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         req,
  input  logic [3*LEN_W-1:0] req_len,
  input  logic               abort,
  output logic [2:0]         gnt,
  output logic               valid_count,
  output logic [3:0]         cnt,
  output logic               wrap,
  output logic [2:0]         done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       owner;
  logic [1:0]       pick;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] pick_len;
  logic [2:0]       owner_oh;
  logic             grant_now;

`ifdef CNT_SCHED_RR_EN
  logic [1:0]       last_owner;
`endif

  assign grant_now = (state == IDLE) && (req != 3'b000);

  // Winner selection; only meaningful when some req bit is set.
  always_comb begin
    pick = 2'd0;
`ifdef CNT_SCHED_RR_EN
    case (last_owner)
      2'd0: begin
        if (req[1])      pick = 2'd1;
        else if (req[2]) pick = 2'd2;
        else             pick = 2'd0;
      end
      2'd1: begin
        if (req[2])      pick = 2'd2;
        else if (req[0]) pick = 2'd0;
        else             pick = 2'd1;
      end
      default: begin
        if (req[0])      pick = 2'd0;
        else if (req[1]) pick = 2'd1;
        else             pick = 2'd2;
      end
    endcase
`else
    if (req[0])      pick = 2'd0;
    else if (req[1]) pick = 2'd1;
    else             pick = 2'd2;
`endif
  end

  always_comb begin
    pick_len = '0;
    case (pick)
      2'd0:    pick_len = req_len[LEN_W-1:0];
      2'd1:    pick_len = req_len[2*LEN_W-1:LEN_W];
      default: pick_len = req_len[3*LEN_W-1:2*LEN_W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_now) state_nxt = (pick_len != '0) ? RUN : DONE;
      end
      RUN: begin
        if ((rem == LEN_W'(1)) || abort) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping and the shadow counter; cnt survives across bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 2'd0;
      rem   <= '0;
      cnt   <= 4'd0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (grant_now) begin
        owner <= pick;
        rem   <= pick_len;
      end else if (state == RUN) begin
        rem <= rem - LEN_W'(1);
        if (cnt == 4'd11) begin
          cnt  <= 4'd0;
          wrap <= 1'b1;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end
    end
  end

`ifdef CNT_SCHED_RR_EN
  // Reset value 2 makes requester 0 the first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_owner <= 2'd2;
    else if (grant_now) last_owner <= pick;
  end
`endif

  assign owner_oh    = 3'b001 << owner;
  assign busy        = (state != IDLE);
  assign gnt         = busy ? owner_oh : 3'b000;
  assign valid_count = (state == RUN);
  assign done        = (state == DONE) ? owner_oh : 3'b000;

endmodule

// File: tb/tb_cnt_sched.sv
// tb/tb_cnt_sched.sv - scoreboard bench for cnt_sched
`timescale 1ns/1ps
module tb_cnt_sched;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2:0]         req = 3'b000;
  logic [3*LEN_W-1:0] req_len = '0;
  logic               abort = 1'b0;
  logic [2:0]         gnt;
  logic               valid_count;
  logic [3:0]         cnt;
  logic               wrap;
  logic [2:0]         done;
  logic               busy;

  cnt_sched #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .abort(abort),
    .gnt(gnt), .valid_count(valid_count), .cnt(cnt), .wrap(wrap),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] done;
    int         cnt;
    int         nv;
    int         ng;
    int         nw;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  int   exp_cnt  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},   int'(gnt), 0);
    chk({tag, "_valid"}, int'(valid_count), 0);
    chk({tag, "_cnt"},   int'(cnt), 0);
    chk({tag, "_wrap"},  int'(wrap), 0);
    chk({tag, "_done"},  int'(done), 0);
    chk({tag, "_busy"},  int'(busy), 0);
  endtask

  // Reference model of the mod-12 counter: advance by k counts, report wraps.
  task automatic adv(input int k, output int w);
    w = 0;
    for (int i = 0; i < k; i++) begin
      if (exp_cnt == 11) begin
        exp_cnt = 0;
        w++;
      end else begin
        exp_cnt++;
      end
    end
  endtask

  task automatic push_exp(input logic [2:0] d, input int taken);
    exp_t e;
    int   w;
    adv(taken, w);
    e.done = d;
    e.cnt  = exp_cnt;
    e.nv   = taken;
    e.ng   = taken + 1;
    e.nw   = w;
    sb.push_back(e);
  endtask

  // One burst from IDLE; abort_at>0 raises abort in that RUN cycle.
  task automatic run_burst(input logic [2:0] r, input int len, input int abort_at,
                           input bit change_mid, input string tag);
    int idx;
    int taken;
    int n;
    bit seen;
    idx   = r[0] ? 0 : (r[1] ? 1 : 2);
    taken = (abort_at > 0 && abort_at < len) ? abort_at : len;
    push_exp(r, taken);
    @(posedge clk);
    #1;
    req = r;
    req_len = {3{4'hA}};
    req_len[idx*LEN_W +: LEN_W] = LEN_W'(len);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (abort_at > 0) abort = (n == abort_at + 1);
      if (change_mid && n == 2) begin
        req = 3'b000;
        req_len = '1;
      end
      if (done != 3'b000) seen = 1'b1;
    end
    req = 3'b000;
    if (abort_at > 0) abort = 1'b0;
    chk({tag, "_latency"}, n, taken + 2);
  endtask

  // Monitor: accumulates per-burst activity and scores it at each done pulse.
  initial begin
    int   nv, ng, nw, nb;
    exp_t e;
    nv = 0; ng = 0; nw = 0; nb = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nv = 0; ng = 0; nw = 0; nb = 0;
      end else begin
        chk("onehot_gnt_done", int'($onehot0(gnt) && $onehot0(done)), 1);
        if (gnt != 3'b000) ng++;
        if (busy)          nb++;
        if (valid_count)   nv++;
        if (wrap)          nw++;
        if (done != 3'b000) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", int'(done), 0);
          end else begin
            e = sb.pop_front();
            chk("done_owner",   int'(done), int'(e.done));
            chk("gnt_at_done",  int'(gnt), int'(e.done));
            chk("cnt_at_done",  int'(cnt), e.cnt);
            chk("valid_cycles", nv, e.nv);
            chk("gnt_cycles",   ng, e.ng);
            chk("busy_cycles",  nb, e.ng);
            chk("wrap_pulses",  nw, e.nw);
          end
          nv = 0; ng = 0; nw = 0; nb = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          seen;
    logic [2:0]  cont_g [4];
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_burst(3'b001, 5, 0, 1'b0, "single");      // cnt 0 -> 5
    run_burst(3'b001, 4, 0, 1'b0, "prewrap");     // cnt 5 -> 9
    run_burst(3'b010, 4, 0, 1'b0, "wrap");        // 10,11,0,1 with one wrap
    run_burst(3'b100, 8, 3, 1'b0, "abort");       // 3 counts -> 4
    abort = 1'b1;                                 // must be ignored outside RUN
    run_burst(3'b010, 0, 0, 1'b0, "zero_len");    // cnt stays 4
    abort = 1'b0;
    run_burst(3'b100, 3, 0, 1'b1, "req_change");  // req dropped mid-burst -> 7

`ifdef CNT_SCHED_RR_EN
    cont_g = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    cont_g = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    for (int i = 0; i < 4; i++) push_exp(cont_g[i], 1);
    @(posedge clk);
    #1;
    req = 3'b111;
    req_len = {4'd1, 4'd1, 4'd1};
    seen = 0;
    for (int n = 0; n < 60 && seen < 4; n++) begin
      @(negedge clk);
      if (done != 3'b000) seen++;
    end
    req = 3'b000;
    chk("contention_bursts", seen, 4);

    @(posedge clk);
    #1;
    req = 3'b001;
    req_len = {4'd0, 4'd0, 4'd6};
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req = 3'b000;
    #1;
    chk_quiet("midrun_reset");
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_idle", int'(busy), 0);
    run_burst(3'b001, 2, 0, 1'b0, "post_reset");  // cnt 0 -> 2

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
